// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - instruction memory and decode-side handshake bundle for fetch_buffer
// Signals:
//   imem_req/imem_addr      fetch request and word-aligned address (master drives)
//   imem_ack/imem_rdata     response strobe and fetched word (slave drives)
//   out_valid/out_instr/out_pc/out_pc4  queue head toward decode (master drives)
//   out_ready               decode accepts the head (slave drives)
// Modports: master = fetch_buffer side, slave = memory/decode environment side.

interface fetch_buffer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output out_valid, out_instr, out_pc, out_pc4,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  out_valid, out_instr, out_pc, out_pc4,
    output out_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch queue with single outstanding request and redirect flush
// Ports:
//   clk          single clock, rising edge
//   nrst         asynchronous active-low reset
//   bus          fetch_buffer_if.master: imem request/response and decode head stream
//   redirect     branch/jump taken: flush queue and restart at redirect_pc
//   redirect_pc  restart address (bits [1:0] ignored)
//   count        number of queued entries
//   stall_cycles (only with FETCH_BUFFER_STATS_EN) saturating count of cycles
//                where decode was ready but the queue was empty
// Optional feature macro: FETCH_BUFFER_STATS_EN

module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   nrst,
  fetch_buffer_if.master         bus,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] count
`ifdef FETCH_BUFFER_STATS_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_SPACE} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic          drop, drop_n;
  logic [CW-1:0] count_n, count_after;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic          valid, push, pop, imem_req;

  assign valid = (count != '0);
  // An ack only completes a request while in REQ; a dropped or redirected
  // response never reaches the queue.
  assign push  = (state == REQ) && bus.imem_ack && !drop && !redirect;
  assign pop   = valid && bus.out_ready;
  assign count_after = count + CW'(push) - CW'(pop);

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    drop_n     = drop;
    count_n    = count_after;
    imem_req   = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        // While drop is set the old request is still in flight, so no new
        // request may be presented until its ack is swallowed.
        imem_req = !drop;
        if (bus.imem_ack) begin
          if (drop) begin
            drop_n = 1'b0;
          end else begin
            fetch_pc_n = fetch_pc + 32'd4;
            // The next request reserves a slot, so keep fetching only if
            // at least one slot remains free after this push.
            state_n = (count_after < FULL) ? REQ : WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: if (pop) state_n = REQ;
      default: state_n = IDLE;
    endcase
    if (redirect) begin
      state_n    = REQ;
      fetch_pc_n = redirect_pc & 32'hFFFF_FFFC;
      count_n    = '0;
      // A request still in flight (not acked this cycle) must be discarded
      // when its response finally arrives.
      drop_n     = (state == REQ) && !bus.imem_ack;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC_ALIGNED;
      drop     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      drop     <= drop_n;
      count    <= count_n;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = valid;
  // Head fields are forced to zero when empty so stale storage never leaks.
  assign bus.out_instr = valid ? q_instr[rd_ptr] : '0;
  assign bus.out_pc    = valid ? q_pc[rd_ptr] : '0;
  assign bus.out_pc4   = valid ? q_pc[rd_ptr] + 32'd4 : '0;

`ifdef FETCH_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cycles <= '0;
    end else if (bus.out_ready && !valid && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
